// File: rtl/dfu_ip_pingpong_loader.sv
// Ping-pong SRAM loader: pulls bursts from an external read arbiter into one of
// two banked buffers while the consumer reads the other, with a per-buffer
// full/release ownership protocol between loader and consumer.
module dfu_ip_pingpong_loader #(
  parameter int NUM_BANKS  = 8,
  parameter int ES         = 16,
  parameter int SRAM_DEPTH = 256,
  parameter int AXI_ADDR_W = 32,
  localparam int ADDR_W    = $clog2(SRAM_DEPTH),
  localparam int DATA_W    = NUM_BANKS * ES
) (
  input  logic                          clk,
  input  logic                          rst,
  // load command
  input  logic                          cmd_vld,
  output logic                          cmd_rdy,
  input  logic [AXI_ADDR_W-1:0]         cmd_addr,
  input  logic [ADDR_W:0]               cmd_len,
  // arbiter request / grant and read burst
  output logic                          dfu2ar_grant_req,
  input  logic                          ar2dfu_grant,
  output logic [AXI_ADDR_W-1:0]         dfu2ar_addr,
  output logic                          dfu2ar_addr_vld,
  output logic [ADDR_W:0]               dfu2ar_len,
  input  logic [DATA_W-1:0]             ar2dfu_data_in,
  input  logic                          ar2dfu_data_in_vld,
  input  logic                          ar2dfu_ack_data_done,
  // buffer status
  output logic [1:0]                    buf_full,
  output logic                          load_done,
  output logic                          load_err,
  // consumer read port
  input  logic                          rd_buf_sel,
  input  logic [NUM_BANKS-1:0]          rd_en,
  input  logic [NUM_BANKS*ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  output logic [NUM_BANKS-1:0]          rd_data_vld,
  input  logic [1:0]                    buf_release
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_e;

  // Longest burst that fits in one buffer.
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(SRAM_DEPTH);

  state_e                  state_q;
  logic                    fill_ptr_q;
  logic [1:0]              buf_full_q, buf_full_d;
  logic [AXI_ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]         len_q;
  logic [ADDR_W:0]         cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    ok_q;
  logic                    grant_req_q;
  logic                    addr_vld_q;
  logic                    load_done_q;
  logic                    load_err_q;
  logic                    beat_wr;
  logic                    beat_drop;

  logic [ES-1:0]           mem_q [2][NUM_BANKS][SRAM_DEPTH];
  logic [DATA_W-1:0]       rd_data_q;
  logic [NUM_BANKS-1:0]    rd_vld_q;

  // Command is accepted only in IDLE with the target buffer free; held low in reset.
  assign cmd_rdy = rst && (state_q == S_IDLE) && !buf_full_q[fill_ptr_q];

  assign dfu2ar_grant_req = grant_req_q;
  assign dfu2ar_addr      = addr_q;
  assign dfu2ar_addr_vld  = addr_vld_q;
  assign dfu2ar_len       = len_q;
  assign buf_full         = buf_full_q;
  assign load_done        = load_done_q;
  assign load_err         = load_err_q;
  assign rd_data          = rd_data_q;
  assign rd_data_vld      = rd_vld_q;

  // Beat accounting in DATA: in-range beats are written, overflow beats poison the load.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    beat_wr   = 1'b0;
    beat_drop = 1'b0;
    if (state_q == S_DATA && ar2dfu_data_in_vld) begin
      beat_wr   = (cnt_q < len_q);
      beat_drop = !(cnt_q < len_q);
    end
    cnt_d = cnt_q + (ADDR_W + 1)'(beat_wr);
    err_d = err_q | beat_drop;
  end

  // Ownership flags: consumer release and loader completion both apply; set wins on the same buffer.
  always_comb begin
    buf_full_d = buf_full_q & ~buf_release;
    if (state_q == S_DONE && ok_q) begin
      buf_full_d[fill_ptr_q] = 1'b1;
    end
  end

  // Load sequencer with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q     <= S_IDLE;
      fill_ptr_q  <= 1'b0;
      buf_full_q  <= 2'b00;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      ok_q        <= 1'b0;
      grant_req_q <= 1'b0;
      addr_vld_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      buf_full_q  <= buf_full_d;
      case (state_q)
        S_IDLE: begin
          if (cmd_vld && cmd_rdy) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            if (cmd_len > MAX_LEN) begin
              // Oversized request is rejected without touching the arbiter.
              load_err_q <= 1'b1;
            end else if (cmd_len == '0) begin
              // Empty load completes trivially.
              ok_q    <= 1'b1;
              state_q <= S_DONE;
            end else begin
              grant_req_q <= 1'b1;
              state_q     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (ar2dfu_grant) begin
            addr_vld_q <= 1'b1;
            state_q    <= S_ADDR;
          end
        end
        S_ADDR: begin
          addr_vld_q <= 1'b0;
          state_q    <= S_DATA;
        end
        S_DATA: begin
          cnt_q <= cnt_d;
          err_q <= err_d;
          if (ar2dfu_ack_data_done) begin
            ok_q        <= (cnt_d == len_q) && !err_d;
            grant_req_q <= 1'b0;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (ok_q) begin
            load_done_q <= 1'b1;
            fill_ptr_q  <= ~fill_ptr_q;
          end else begin
            load_err_q  <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Bank writes: lane i of each accepted beat goes to bank i of the fill buffer.
  always_ff @(posedge clk) begin
    // NOTE: SRAM arrays carry no reset; contents are only meaningful once a load marks the buffer full.
    if (beat_wr) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        mem_q[fill_ptr_q][b][cnt_q[ADDR_W-1:0]] <= ar2dfu_data_in[b*ES +: ES];
      end
    end
  end

  // Per-bank read port: one-cycle latency, only from a buffer the consumer owns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
      rd_vld_q  <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rd_en[b] && buf_full_q[rd_buf_sel]) begin
          rd_data_q[b*ES +: ES] <= mem_q[rd_buf_sel][b][rd_addr[b*ADDR_W +: ADDR_W]];
          rd_vld_q[b]           <= 1'b1;
        end else begin
          rd_vld_q[b]           <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dfu_ip_pingpong_loader.sv
// Directed bench for the ping-pong loader: loads, buffer ownership, error
// paths, per-bank reads and mid-burst reset.
module tb_dfu_ip_pingpong_loader;

  localparam int NB     = 8;
  localparam int ES     = 16;
  localparam int DEPTH  = 256;
  localparam int AW     = 32;
  localparam int ADDR_W = 8;
  localparam int DATA_W = NB * ES;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cmd_vld = 1'b0;
  logic                 cmd_rdy;
  logic [AW-1:0]        cmd_addr = '0;
  logic [ADDR_W:0]      cmd_len = '0;
  logic                 grant_req;
  logic                 ar2dfu_grant = 1'b0;
  logic [AW-1:0]        ar_addr;
  logic                 addr_vld;
  logic [ADDR_W:0]      ar_len;
  logic [DATA_W-1:0]    data_in = '0;
  logic                 data_vld = 1'b0;
  logic                 ack_done = 1'b0;
  logic [1:0]           buf_full;
  logic                 load_done;
  logic                 load_err;
  logic                 rd_buf_sel = 1'b0;
  logic [NB-1:0]        rd_en = '0;
  logic [NB*ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0]    rd_data;
  logic [NB-1:0]        rd_data_vld;
  logic [1:0]           buf_release = 2'b00;

  int checks   = 0;
  int failures = 0;

  dfu_ip_pingpong_loader #(
    .NUM_BANKS (NB),
    .ES        (ES),
    .SRAM_DEPTH(DEPTH),
    .AXI_ADDR_W(AW)
  ) u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .cmd_vld              (cmd_vld),
    .cmd_rdy              (cmd_rdy),
    .cmd_addr             (cmd_addr),
    .cmd_len              (cmd_len),
    .dfu2ar_grant_req     (grant_req),
    .ar2dfu_grant         (ar2dfu_grant),
    .dfu2ar_addr          (ar_addr),
    .dfu2ar_addr_vld      (addr_vld),
    .dfu2ar_len           (ar_len),
    .ar2dfu_data_in       (data_in),
    .ar2dfu_data_in_vld   (data_vld),
    .ar2dfu_ack_data_done (ack_done),
    .buf_full             (buf_full),
    .load_done            (load_done),
    .load_err             (load_err),
    .rd_buf_sel           (rd_buf_sel),
    .rd_en                (rd_en),
    .rd_addr              (rd_addr),
    .rd_data              (rd_data),
    .rd_data_vld          (rd_data_vld),
    .buf_release          (buf_release)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge: inputs driven here are sampled
  // at the following edge, outputs read here are the post-edge register values.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat/line pattern: lane i = base + i.
  function automatic logic [DATA_W-1:0] mk_beat(input logic [15:0] base);
    logic [DATA_W-1:0] v;
    for (int i = 0; i < NB; i++) v[i*ES +: ES] = base + 16'(i);
    return v;
  endfunction

  // Handshake a command, grant after gdelay cycles, and stop on entry to DATA.
  task automatic start_load(input logic [AW-1:0] addr, input logic [ADDR_W:0] len, input int gdelay);
    int n;
    n = 0;
    cmd_vld  = 1'b1;
    cmd_addr = addr;
    cmd_len  = len;
    while (!cmd_rdy && n < 50) begin
      tick();
      n++;
    end
    check("cmd_rdy_wait", cmd_rdy, 1'b1);
    tick();
    cmd_vld = 1'b0;
    check("grant_req_up", grant_req, 1'b1);
    check("cmd_rdy_busy", cmd_rdy, 1'b0);
    for (int i = 0; i < gdelay; i++) begin
      check("grant_req_held", grant_req, 1'b1);
      check("no_addr_before_grant", addr_vld, 1'b0);
      tick();
    end
    ar2dfu_grant = 1'b1;
    tick();
    ar2dfu_grant = 1'b0;
    check("addr_vld_pulse", addr_vld, 1'b1);
    check("ar_addr", ar_addr, addr);
    check("ar_len", ar_len, len);
    tick();
    check("addr_vld_single", addr_vld, 1'b0);
    check("grant_req_in_data", grant_req, 1'b1);
  endtask

  // n beats, beat k = mk_beat(base + 16k), end-of-burst on the last one.
  task automatic send_beats(input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) begin
      data_vld = 1'b1;
      data_in  = mk_beat(base + 16'(16 * k));
      ack_done = (k == n - 1);
      tick();
    end
    data_vld = 1'b0;
    ack_done = 1'b0;
  endtask

  // Called in the DONE cycle: check completion pulse and flags.
  task automatic finish_load(input bit exp_ok, input logic [1:0] exp_full);
    check("done_grant_low", grant_req, 1'b0);
    check("done_no_early_pulse", load_done, 1'b0);
    tick();
    check("load_done", load_done, exp_ok);
    check("load_err", load_err, !exp_ok);
    check("buf_full_after_load", buf_full, exp_full);
    tick();
    check("status_pulse_width", {load_done, load_err}, 2'b00);
  endtask

  task automatic do_read(input logic sel, input logic [NB-1:0] en, input logic [NB*ADDR_W-1:0] addr);
    rd_buf_sel = sel;
    rd_en      = en;
    rd_addr    = addr;
    tick();
    rd_en      = '0;
  endtask

  logic [DATA_W-1:0] exp_rd;

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_cmd_rdy", cmd_rdy, 1'b0);
    check("rst_grant_req", grant_req, 1'b0);
    check("rst_addr_vld", addr_vld, 1'b0);
    check("rst_ar_addr", ar_addr, '0);
    check("rst_ar_len", ar_len, '0);
    check("rst_buf_full", buf_full, 2'b00);
    check("rst_status", {load_done, load_err}, 2'b00);
    check("rst_rd_vld", rd_data_vld, '0);
    check("rst_rd_data", rd_data, '0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("idle_cmd_rdy", cmd_rdy, 1'b1);

    // Load 1: len 4 @0x1000, grant after 3 cycles, done with beat 4 -> buffer 0
    start_load(32'h1000, 9'd4, 3);
    send_beats(4, 16'h0010);
    finish_load(1'b1, 2'b01);
    check("fill_ptr_to_1_rdy", cmd_rdy, 1'b1);
    do_read(1'b0, 8'hFF, {NB{8'd2}});
    check("rd_buf0_addr2", rd_data, mk_beat(16'h0030));
    check("rd_buf0_vld", rd_data_vld, 8'hFF);

    // Load 2: len 2 -> buffer 1
    start_load(32'h2000, 9'd2, 0);
    send_beats(2, 16'h0020);
    finish_load(1'b1, 2'b11);

    // Independent banks: lane 0 addr 0, lane 7 addr 1, others hold
    do_read(1'b1, 8'h81, {8'd1, {7{8'd0}}});
    exp_rd = mk_beat(16'h0030);
    exp_rd[0 +: ES]      = 16'h0020;
    exp_rd[7*ES +: ES]   = 16'h0037;
    check("rd_lane_indep_data", rd_data, exp_rd);
    check("rd_lane_indep_vld", rd_data_vld, 8'h81);

    // Both buffers full: third command waits for a release
    cmd_vld  = 1'b1;
    cmd_addr = 32'h3000;
    cmd_len  = 9'd6;
    for (int i = 0; i < 3; i++) begin
      check("cmd_rdy_blocked", cmd_rdy, 1'b0);
      tick();
    end
    buf_release = 2'b01;
    tick();
    buf_release = 2'b00;
    check("release0_buf_full", buf_full, 2'b10);
    check("release0_cmd_rdy", cmd_rdy, 1'b1);
    start_load(32'h3000, 9'd6, 1);
    send_beats(6, 16'h0050);
    finish_load(1'b1, 2'b11);

    // Release buffer 1, then release it again while empty
    buf_release = 2'b10;
    tick();
    buf_release = 2'b00;
    check("release1_buf_full", buf_full, 2'b01);
    buf_release = 2'b10;
    tick();
    buf_release = 2'b00;
    check("release_empty_ignored", buf_full, 2'b01);

    // Full buffer 0 read at addr 5; empty buffer 1 read returns nothing
    do_read(1'b0, 8'hFF, {NB{8'd5}});
    check("rd_buf0_addr5", rd_data, mk_beat(16'h00A0));
    check("rd_buf0_addr5_vld", rd_data_vld, 8'hFF);
    do_read(1'b1, 8'hFF, {NB{8'd5}});
    check("rd_empty_vld", rd_data_vld, 8'h00);
    check("rd_empty_hold", rd_data, mk_beat(16'h00A0));
    check("fill_ptr_1_rdy", cmd_rdy, 1'b1);

    // Short burst: len 4, done after 3 beats
    start_load(32'h4000, 9'd4, 0);
    send_beats(3, 16'h0060);
    finish_load(1'b0, 2'b01);
    check("short_fill_ptr_kept", cmd_rdy, 1'b1);

    // Overrun: len 2, 3 beats (third dropped)
    start_load(32'h4100, 9'd2, 0);
    send_beats(3, 16'h0060);
    finish_load(1'b0, 2'b01);
    check("overrun_fill_ptr_kept", cmd_rdy, 1'b1);

    // Oversized command: SRAM_DEPTH+1
    cmd_vld  = 1'b1;
    cmd_addr = 32'h4200;
    cmd_len  = 9'(DEPTH + 1);
    tick();
    cmd_vld = 1'b0;
    check("oversize_err", load_err, 1'b1);
    check("oversize_no_grant", grant_req, 1'b0);
    check("oversize_buf_full", buf_full, 2'b01);
    check("oversize_back_idle", cmd_rdy, 1'b1);
    tick();
    check("oversize_err_pulse", load_err, 1'b0);
    check("oversize_no_grant2", grant_req, 1'b0);

    // Zero-length command fills buffer 1 while buffer 0 is released in the same cycle
    cmd_vld = 1'b1;
    cmd_len = 9'd0;
    tick();
    cmd_vld = 1'b0;
    check("len0_no_grant", grant_req, 1'b0);
    check("len0_no_early_done", load_done, 1'b0);
    check("len0_busy", cmd_rdy, 1'b0);
    buf_release = 2'b01;
    tick();
    buf_release = 2'b00;
    check("len0_done", load_done, 1'b1);
    check("len0_set_and_release", buf_full, 2'b10);
    check("len0_no_grant2", grant_req, 1'b0);
    check("len0_fill_ptr_0_rdy", cmd_rdy, 1'b1);
    tick();
    check("len0_done_pulse", load_done, 1'b0);

    // Reset in the middle of DATA after 2 of 4 beats
    start_load(32'h5000, 9'd4, 0);
    for (int k = 0; k < 2; k++) begin
      data_vld = 1'b1;
      data_in  = mk_beat(16'h00E0 + 16'(16 * k));
      tick();
    end
    data_vld = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_grant_req", grant_req, 1'b0);
    check("midrst_buf_full", buf_full, 2'b00);
    check("midrst_cmd_rdy", cmd_rdy, 1'b0);
    check("midrst_addr_vld", addr_vld, 1'b0);
    check("midrst_rd_vld", rd_data_vld, '0);
    tick();
    rst = 1'b1;
    send_beats(2, 16'h0000);
    check("postrst_idle_rdy", cmd_rdy, 1'b1);
    check("postrst_no_grant", grant_req, 1'b0);
    tick();
    check("postrst_no_status", {load_done, load_err}, 2'b00);
    check("postrst_buf_full", buf_full, 2'b00);

    // Fresh load of buffer 0 addr 0..1; addr 2..3 must still hold pre-reset contents
    start_load(32'h6000, 9'd2, 0);
    send_beats(2, 16'h00C0);
    finish_load(1'b1, 2'b01);
    do_read(1'b0, 8'hFF, {NB{8'd1}});
    check("postrst_rd_addr1", rd_data, mk_beat(16'h00D0));
    do_read(1'b0, 8'hFF, {NB{8'd2}});
    check("postrst_rd_addr2", rd_data, mk_beat(16'h0070));
    do_read(1'b0, 8'hFF, {NB{8'd3}});
    check("postrst_rd_addr3", rd_data, mk_beat(16'h0080));
    check("postrst_rd_vld", rd_data_vld, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dfu_ip_pingpong_loader.md
DFU_IP_PINGPONG_LOADER -- requirements
Module: dfu_ip_pingpong_loader

Interface
REQ-001 Parameter NUM_BANKS, default 8: number of SRAM banks per buffer (lanes per beat).
REQ-002 Parameter ES, default 16: element width per bank entry.
REQ-003 Parameter SRAM_DEPTH, default 256: entries per bank per buffer; ADDR_W = clog2(SRAM_DEPTH).
REQ-004 Parameter AXI_ADDR_W, default 32: external address width; beat width DATA_W = NUM_BANKS*ES.
REQ-005 clk  in  1  single clock, all logic rising-edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 cmd_vld / cmd_rdy  in/out  1/1  load command handshake; transfer when both high.
REQ-008 cmd_addr  in  AXI_ADDR_W  external base address; cmd_len  in  ADDR_W+1  beat count.
REQ-009 dfu2ar_grant_req  out 1; ar2dfu_grant  in 1  arbiter request/grant.
REQ-010 dfu2ar_addr  out AXI_ADDR_W; dfu2ar_addr_vld  out 1; dfu2ar_len  out ADDR_W+1  read burst request.
REQ-011 ar2dfu_data_in  in DATA_W; ar2dfu_data_in_vld  in 1; ar2dfu_ack_data_done  in 1  returned beats and end-of-burst.
REQ-012 buf_full  out 2  per-buffer "loaded, owned by consumer" flags; load_done  out 1  one-cycle pulse; load_err  out 1  one-cycle pulse.
REQ-013 rd_buf_sel  in 1; rd_en  in NUM_BANKS; rd_addr  in NUM_BANKS*ADDR_W  per-bank read port.
REQ-014 rd_data  out NUM_BANKS*ES; rd_data_vld  out NUM_BANKS  per-bank read return.
REQ-015 buf_release  in 2  one-cycle pulse per buffer, consumer frees it.

Function
REQ-016 Two buffers (0,1), each NUM_BANKS banks x SRAM_DEPTH x ES; fill pointer starts at buffer 0, toggles after each successful load.
REQ-017 FSM states: IDLE, REQ, ADDR, DATA, DONE.
REQ-018 IDLE: cmd_rdy=1 only when buf_full[fill_ptr]=0; on handshake latch addr/len, clear beat counter.
REQ-019 Accepted cmd_len=0: go to DONE directly, no arbiter traffic.
REQ-020 Accepted cmd_len>SRAM_DEPTH: pulse load_err next cycle, return to IDLE, no arbiter traffic, fill_ptr unchanged.
REQ-021 REQ: dfu2ar_grant_req held high until ar2dfu_grant sampled high; then ADDR.
REQ-022 ADDR: dfu2ar_addr_vld high exactly one cycle with latched addr and len; then DATA; grant_req stays high through DATA.
REQ-023 DATA: each cycle ar2dfu_data_in_vld=1 and counter<len, lane i (bits i*ES+:ES) written to bank i of fill buffer at address = counter; counter+1.
REQ-024 Beats arriving when counter=len are dropped and set a sticky error for this load.
REQ-025 ar2dfu_ack_data_done (may coincide with last beat, which is still written): go DONE; if counter (after this cycle's write) != len, or sticky error, the load is an error.
REQ-026 DONE (one cycle): grant_req low; success -> buf_full[fill_ptr] set, load_done pulse, fill_ptr toggles; error -> load_err pulse, buffer stays empty, fill_ptr unchanged; then IDLE.
REQ-027 Read: rd_en[i]=1 -> rd_data lane i = bank i of buffer rd_buf_sel at rd_addr[i], rd_data_vld[i]=1, one-cycle latency; banks independent.
REQ-028 Read of a buffer with buf_full=0: rd_data_vld lane 0, rd_data lane holds previous value.
REQ-029 buf_release[b] clears buf_full[b] next cycle; release of an empty buffer is ignored.
REQ-030 Release of buffer b and DONE setting buffer b' in the same cycle both take effect; set wins if b=b'.
REQ-031 cmd_rdy low whenever FSM not in IDLE; never more than one outstanding load.

Reset
REQ-032 rst low asynchronously forces: state IDLE, fill_ptr=0, buf_full=00, counter=0, all handshake outputs 0, dfu2ar_addr/len=0, rd_data=0, rd_data_vld=0, load_done/load_err=0.
REQ-033 SRAM contents not reset; reset mid-load abandons the burst; later beats ignored while IDLE.

Verification
REQ-034 cmd len=4 addr=0x1000, grant after 3 cycles, 4 beats, done with beat 4 -> addr_vld one cycle with 0x1000/len 4, load_done, buf_full=01, fill_ptr=1.
REQ-035 Two loads without release, then third cmd_vld -> cmd_rdy stays 0 until buf_release=01; next load fills buffer 0.
REQ-036 len=4, done after 3 beats -> load_err, buf_full unchanged; len=2 with 3 beats -> third dropped, load_err.
REQ-037 cmd len=0 -> load_done two cycles after handshake, no grant_req; len=SRAM_DEPTH+1 -> load_err, no grant_req.
REQ-038 Buffer 0 full with lane pattern 0xA0+i at addr 5; rd_en=all ones, rd_addr=5 -> next cycle rd_data lane i=0xA0+i, vld all ones; same on buffer 1 (empty) -> vld 0.
REQ-039 Assert rst low during DATA after 2 of 4 beats -> immediate IDLE, buf_full=00, grant_req=0; remaining beats produce no writes.
